// File: rtl/core_run_sequencer.sv
// Core-domain run sequencer: drives core reset, execute enable and base address.
// Optional breakpoint support is enabled by defining CORE_SEQ_BREAKPOINT_EN.
module core_run_sequencer #(
   parameter int ADDR_WIDTH = 32,
   parameter int STAT_WIDTH = 16,
   parameter int RST_CYCLES = 4
) (
   input  logic                  CCLK,
   input  logic                  CRST,
   input  logic                  CMD_START,
   input  logic                  CMD_STEP,
   input  logic                  CMD_STOP,
   input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
   input  logic [31:0]           CMD_MAXCYC,
`ifdef CORE_SEQ_BREAKPOINT_EN
   input  logic [31:0]           BKPT_CYCLE,
`endif
   output logic                  CORE_RST,
   output logic                  CEXEC,
   output logic [ADDR_WIDTH-1:0] CMEM_ADDR,
   input  logic [STAT_WIDTH-1:0] CSTAT,
   output logic [2:0]            RUN_STATE,
   output logic [31:0]           CYCLES,
   output logic                  DONE,
   output logic [1:0]            REASON,
   output logic [STAT_WIDTH-1:0] RESULT_STAT
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RESET = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_STEP  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [7:0] RST_CNT_LAST = 8'(RST_CYCLES - 1);

   state_t                r_state;
   logic [7:0]            r_rst_cnt;
   logic                  r_core_rst;
   logic                  r_cexec;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_maxcyc;
   logic [31:0]           r_cycles;
   logic                  r_done;
   logic [1:0]            r_reason;
   logic [STAT_WIDTH-1:0] r_result;

   logic [31:0] w_cyc_inc;
   logic        w_fault;
   logic        w_halt;
   logic        w_timeout;
   logic        w_exit;
   logic [1:0]  w_exit_reason;
   logic        w_bkpt_hit;

   // Count of executed cycles including the one in progress; saturates.
   assign w_cyc_inc = (r_cycles == 32'hFFFF_FFFF) ? r_cycles : r_cycles + 32'd1;

   assign w_fault       = CSTAT[14];
   assign w_halt        = CSTAT[15];
   assign w_timeout     = (r_maxcyc != 32'd0) && (w_cyc_inc == r_maxcyc);
   assign w_exit        = w_fault || w_halt || w_timeout;
   assign w_exit_reason = w_fault ? 2'd3 : (w_halt ? 2'd1 : 2'd2);

`ifdef CORE_SEQ_BREAKPOINT_EN
   // Trigger only when the count actually moves onto the value, so a resume
   // (or a saturated counter) never re-fires on the same value.
   assign w_bkpt_hit = (r_state == S_RUN) && (BKPT_CYCLE != 32'd0) &&
                       (w_cyc_inc == BKPT_CYCLE) && (w_cyc_inc != r_cycles);
`else
   assign w_bkpt_hit = 1'b0;
`endif

   always_ff @(posedge CCLK) begin
      if (CRST) begin
         r_state    <= S_IDLE;
         r_rst_cnt  <= 8'd0;
         r_core_rst <= 1'b1;
         r_cexec    <= 1'b0;
         r_addr     <= '0;
         r_maxcyc   <= 32'd0;
         r_cycles   <= 32'd0;
         r_done     <= 1'b0;
         r_reason   <= 2'd0;
         r_result   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (CMD_START) begin
                  r_addr     <= CMD_ADDR;
                  r_maxcyc   <= CMD_MAXCYC;
                  r_cycles   <= 32'd0;
                  r_reason   <= 2'd0;
                  r_result   <= '0;
                  r_rst_cnt  <= 8'd0;
                  r_core_rst <= 1'b1;
                  r_state    <= S_RESET;
               end
            end
            S_RESET: begin
               if (r_rst_cnt == RST_CNT_LAST) begin
                  r_state    <= S_RUN;
                  r_core_rst <= 1'b0;
                  r_cexec    <= 1'b1;
               end else begin
                  r_rst_cnt <= r_rst_cnt + 8'd1;
               end
            end
            S_RUN, S_STEP: begin
               r_cycles <= w_cyc_inc;
               if (w_exit) begin
                  r_state  <= S_DONE;
                  r_cexec  <= 1'b0;
                  r_done   <= 1'b1;
                  r_reason <= w_exit_reason;
                  r_result <= CSTAT;
               end else if ((r_state == S_STEP) || w_bkpt_hit || CMD_STOP) begin
                  // STOP is only honoured in RUN; a STEP cycle always returns to PAUSE.
                  r_state <= S_PAUSE;
                  r_cexec <= 1'b0;
               end
            end
            S_PAUSE: begin
               if (CMD_STOP) begin
                  r_state  <= S_DONE;
                  r_done   <= 1'b1;
                  r_reason <= 2'd3;
                  r_result <= CSTAT;
               end else if (CMD_START) begin
                  r_state <= S_RUN;
                  r_cexec <= 1'b1;
               end else if (CMD_STEP) begin
                  r_state <= S_STEP;
                  r_cexec <= 1'b1;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_core_rst <= 1'b1;
               r_cexec    <= 1'b0;
            end
         endcase
      end
   end

   assign CORE_RST    = r_core_rst;
   assign CEXEC       = r_cexec;
   assign CMEM_ADDR   = r_addr;
   assign RUN_STATE   = r_state;
   assign CYCLES      = r_cycles;
   assign DONE        = r_done;
   assign REASON      = r_reason;
   assign RESULT_STAT = r_result;

endmodule

// File: tb/tb_core_run_sequencer.sv
// Directed bench for core_run_sequencer: reset, start latency, halt, timeout,
// pause/step/resume, exit priorities and mid-run reset.
module tb_core_run_sequencer;
   logic        CCLK;
   logic        CRST;
   logic        CMD_START;
   logic        CMD_STEP;
   logic        CMD_STOP;
   logic [31:0] CMD_ADDR;
   logic [31:0] CMD_MAXCYC;
`ifdef CORE_SEQ_BREAKPOINT_EN
   logic [31:0] BKPT_CYCLE;
`endif
   logic        CORE_RST;
   logic        CEXEC;
   logic [31:0] CMEM_ADDR;
   logic [15:0] CSTAT;
   logic [2:0]  RUN_STATE;
   logic [31:0] CYCLES;
   logic        DONE;
   logic [1:0]  REASON;
   logic [15:0] RESULT_STAT;

   int total = 0;
   int bad   = 0;

   core_run_sequencer #(.ADDR_WIDTH(32), .STAT_WIDTH(16), .RST_CYCLES(4)) dut (
      .CCLK(CCLK), .CRST(CRST),
      .CMD_START(CMD_START), .CMD_STEP(CMD_STEP), .CMD_STOP(CMD_STOP),
      .CMD_ADDR(CMD_ADDR), .CMD_MAXCYC(CMD_MAXCYC),
`ifdef CORE_SEQ_BREAKPOINT_EN
      .BKPT_CYCLE(BKPT_CYCLE),
`endif
      .CORE_RST(CORE_RST), .CEXEC(CEXEC), .CMEM_ADDR(CMEM_ADDR),
      .CSTAT(CSTAT), .RUN_STATE(RUN_STATE), .CYCLES(CYCLES),
      .DONE(DONE), .REASON(REASON), .RESULT_STAT(RESULT_STAT)
   );

   initial CCLK = 1'b0;
   always #5 CCLK = ~CCLK;

   task automatic tick();
      @(posedge CCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_run(input logic [31:0] addr, input logic [31:0] maxcyc);
      CMD_ADDR   = addr;
      CMD_MAXCYC = maxcyc;
      CMD_START  = 1'b1;
      tick();
      CMD_START  = 1'b0;
   endtask

   // Advance until CEXEC rises, with a bounded budget.
   task automatic wait_exec();
      int n = 0;
      while (CEXEC !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk("wait_exec", 64'(CEXEC), 64'h1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_state"},  64'(RUN_STATE),   64'h0);
      chk({tag, "_crst"},   64'(CORE_RST),    64'h1);
      chk({tag, "_cexec"},  64'(CEXEC),       64'h0);
      chk({tag, "_addr"},   64'(CMEM_ADDR),   64'h0);
      chk({tag, "_cycles"}, 64'(CYCLES),      64'h0);
      chk({tag, "_done"},   64'(DONE),        64'h0);
      chk({tag, "_reason"}, 64'(REASON),      64'h0);
      chk({tag, "_result"}, 64'(RESULT_STAT), 64'h0);
   endtask

   initial begin
      int ex;
      int n;
      CRST = 1'b1; CMD_START = 1'b0; CMD_STEP = 1'b0; CMD_STOP = 1'b0;
      CMD_ADDR = 32'h0; CMD_MAXCYC = 32'h0; CSTAT = 16'h0;
`ifdef CORE_SEQ_BREAKPOINT_EN
      BKPT_CYCLE = 32'h0;
`endif
      tick(); tick();
      chk_reset_outputs("rst");
      CRST = 1'b0;
      tick();
      chk("idle_crst", 64'(CORE_RST), 64'h1);

      // Start latency: CORE_RST for 4 cycles, then execute.
      start_run(32'h1000, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         chk("rst_phase_crst",  64'(CORE_RST),  64'h1);
         chk("rst_phase_cexec", 64'(CEXEC),     64'h0);
         chk("rst_phase_state", 64'(RUN_STATE), 64'h1);
         tick();
      end
      chk("run_cexec",  64'(CEXEC),     64'h1);
      chk("run_crst",   64'(CORE_RST),  64'h0);
      chk("run_state",  64'(RUN_STATE), 64'h2);
      chk("run_addr",   64'(CMEM_ADDR), 64'h1000);
      chk("run_cycles", 64'(CYCLES),    64'h0);

      // Halt sampled during the 10th execute cycle.
      for (int i = 0; i < 9; i++) tick();
      chk("pre_halt_cycles", 64'(CYCLES), 64'd9);
      CSTAT = 16'h8000;
      tick();
      CSTAT = 16'h0000;
      chk("halt_done",   64'(DONE),        64'h1);
      chk("halt_cexec",  64'(CEXEC),       64'h0);
      chk("halt_reason", 64'(REASON),      64'h1);
      chk("halt_cycles", 64'(CYCLES),      64'd10);
      chk("halt_result", 64'(RESULT_STAT), 64'h8000);
      chk("halt_state",  64'(RUN_STATE),   64'h5);
      tick();
      chk("halt_done_pulse", 64'(DONE),      64'h0);
      chk("halt_hold_addr",  64'(CMEM_ADDR), 64'h1000);

      // Timeout after exactly 25 execute cycles; restart from DONE clears results.
      CSTAT = 16'h0123;
      start_run(32'h2000, 32'd25);
      chk("restart_reason", 64'(REASON),      64'h0);
      chk("restart_result", 64'(RESULT_STAT), 64'h0);
      chk("restart_cycles", 64'(CYCLES),      64'h0);
      chk("restart_crst",   64'(CORE_RST),    64'h1);
      ex = 0; n = 0;
      while (DONE !== 1'b1 && n < 200) begin
         if (CEXEC === 1'b1) ex++;
         tick();
         n++;
      end
      chk("to_done",     64'(DONE),        64'h1);
      chk("to_excount",  64'(ex),          64'd25);
      chk("to_reason",   64'(REASON),      64'h2);
      chk("to_cycles",   64'(CYCLES),      64'd25);
      chk("to_result",   64'(RESULT_STAT), 64'h0123);
      chk("to_addr",     64'(CMEM_ADDR),   64'h2000);
      CSTAT = 16'h0000;

      // STOP during the 7th execute cycle, three STEPs, then resume.
      start_run(32'h3000, 32'd0);
      wait_exec();
      for (int i = 0; i < 6; i++) tick();
      CMD_STOP = 1'b1;
      tick();
      CMD_STOP = 1'b0;
      chk("pause_state",  64'(RUN_STATE), 64'h3);
      chk("pause_cexec",  64'(CEXEC),     64'h0);
      chk("pause_cycles", 64'(CYCLES),    64'd7);
      tick(); tick();
      chk("pause_hold", 64'(CYCLES), 64'd7);
      for (int s = 1; s <= 3; s++) begin
         CMD_STEP = 1'b1;
         tick();
         CMD_STEP = 1'b0;
         chk("step_state", 64'(RUN_STATE), 64'h4);
         chk("step_cexec", 64'(CEXEC),     64'h1);
         tick();
         chk("step_back_state", 64'(RUN_STATE), 64'h3);
         chk("step_back_cexec", 64'(CEXEC),     64'h0);
         chk("step_cycles",     64'(CYCLES),    64'(7 + s));
         tick();
      end
      CMD_START = 1'b1; CMD_STEP = 1'b1;
      tick();
      CMD_START = 1'b0; CMD_STEP = 1'b0;
      chk("resume_state",  64'(RUN_STATE), 64'h2);
      chk("resume_cexec",  64'(CEXEC),     64'h1);
      chk("resume_cycles", 64'(CYCLES),    64'd10);
      tick();
      chk("resume_count", 64'(CYCLES), 64'd11);
      CMD_START = 1'b1; CMD_STEP = 1'b1;
      tick();
      CMD_START = 1'b0; CMD_STEP = 1'b0;
      chk("ign_state",  64'(RUN_STATE), 64'h2);
      chk("ign_cycles", 64'(CYCLES),    64'd12);

      // Fault and STOP together: fault wins.
      CSTAT = 16'hC000; CMD_STOP = 1'b1;
      tick();
      CSTAT = 16'h0000; CMD_STOP = 1'b0;
      chk("fault_done",   64'(DONE),        64'h1);
      chk("fault_reason", 64'(REASON),      64'h3);
      chk("fault_result", 64'(RESULT_STAT), 64'hC000);
      chk("fault_cycles", 64'(CYCLES),      64'd13);

      // STOP in PAUSE aborts, and wins over a coincident START.
      start_run(32'h4000, 32'd0);
      wait_exec();
      CMD_STOP = 1'b1;
      tick();
      chk("abort_pause", 64'(RUN_STATE), 64'h3);
      CMD_START = 1'b1;
      tick();
      CMD_STOP = 1'b0; CMD_START = 1'b0;
      chk("abort_done",   64'(DONE),      64'h1);
      chk("abort_reason", 64'(REASON),    64'h3);
      chk("abort_state",  64'(RUN_STATE), 64'h5);
      chk("abort_cycles", 64'(CYCLES),    64'd1);

`ifdef CORE_SEQ_BREAKPOINT_EN
      // Breakpoint at 12 pauses once; resume runs past it.
      BKPT_CYCLE = 32'd12;
      start_run(32'h5000, 32'd0);
      wait_exec();
      n = 0;
      while (RUN_STATE !== 3'd3 && n < 50) begin
         tick();
         n++;
      end
      chk("bkpt_state",  64'(RUN_STATE), 64'h3);
      chk("bkpt_cycles", 64'(CYCLES),    64'd12);
      CMD_START = 1'b1;
      tick();
      CMD_START = 1'b0;
      tick(); tick();
      chk("bkpt_resume_state",  64'(RUN_STATE), 64'h2);
      chk("bkpt_resume_cycles", 64'(CYCLES),    64'd14);
      BKPT_CYCLE = 32'd0;
`endif

      // Reset mid-run returns to IDLE without a DONE pulse.
      start_run(32'h6000, 32'd0);
      wait_exec();
      tick(); tick();
      CRST = 1'b1;
      tick();
      chk_reset_outputs("midrst");
      CRST = 1'b0;
      tick();
      chk("midrst_no_done", 64'(DONE), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/core_run_sequencer.md
# core_run_sequencer

Core-clock-domain sequencer that drives the execution core's reset, execute-enable and program base address. It sits between the AXI-side register block, which supplies command pulses and configuration, and the core. It runs a reset/run/pause/step/done state machine, counts executed cycles, enforces an optional cycle limit and reports why execution ended.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of CMD_ADDR / CMEM_ADDR
- STAT_WIDTH, 16, width of CSTAT / RESULT_STAT
- RST_CYCLES, 4, cycles CORE_RST is held asserted (1..255)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high (CCLK, CRST).
- CCLK  in  1  core clock
- CRST  in  1  synchronous active-high reset of this block
- CMD_START  in  1  one-cycle pulse: start from IDLE/DONE, resume from PAUSE
- CMD_STEP  in  1  one-cycle pulse: execute one cycle from PAUSE
- CMD_STOP  in  1  one-cycle pulse: RUN->PAUSE, PAUSE->DONE (abort)
- CMD_ADDR  in  ADDR_WIDTH  program base address, latched on start
- CMD_MAXCYC  in  32  cycle limit, latched on start; 0 = unlimited
- CORE_RST  out  1  reset to core, active-high
- CEXEC  out  1  execute enable to core, registered
- CMEM_ADDR  out  ADDR_WIDTH  latched base address to core
- CSTAT  in  STAT_WIDTH  core status; bit 15 = halted, bit 14 = fault
- RUN_STATE  out  3  encoded FSM state
- CYCLES  out  32  count of cycles with CEXEC=1 since start
- DONE  out  1  one-cycle pulse on entry to DONE
- REASON  out  2  0 none, 1 halt, 2 timeout, 3 abort/fault
- RESULT_STAT  out  STAT_WIDTH  CSTAT captured on entry to DONE

## Operation
- States / RUN_STATE: IDLE=0, RESET=1, RUN=2, PAUSE=3, STEP=4, DONE=5.
- IDLE or DONE + CMD_START: latch CMD_ADDR->CMEM_ADDR and CMD_MAXCYC; clear CYCLES, REASON, RESULT_STAT; go to RESET.
- RESET: CORE_RST=1 for exactly RST_CYCLES cycles, then go to RUN.
- RUN: CEXEC=1. CYCLES increments each cycle CEXEC=1. Exits are evaluated on sampled CSTAT, with priority fault > halt > timeout > STOP:
  - CSTAT[14] -> DONE, REASON=3.
  - CSTAT[15] -> DONE, REASON=1.
  - CYCLES reaches MAXCYC (MAXCYC≠0) -> DONE, REASON=2.
  - CMD_STOP -> PAUSE.
- PAUSE: CEXEC=0, counters hold.
  - CMD_START -> RUN.
  - CMD_STEP -> STEP.
  - CMD_STOP -> DONE, REASON=3.
  - If pulses coincide, STOP wins over START, and START wins over STEP.
- STEP: CEXEC=1 for one cycle, CYCLES+1, then the same exit checks as RUN, else PAUSE.
- Commands not listed for the current state are ignored. This includes START during RESET/RUN/STEP and STEP outside PAUSE.
- CYCLES saturates at 0xFFFFFFFF; it does not wrap.
- CMEM_ADDR holds stable from start through DONE and until the next start.

## Timing
- Reset (CRST=1 at clock edge): state IDLE, CORE_RST=1, CEXEC=0, CMEM_ADDR=0, CYCLES=0, DONE=0, REASON=0, RESULT_STAT=0. CRST mid-run aborts immediately, with no DONE pulse.
- In IDLE, CORE_RST=1 (core held in reset). It deasserts only on leaving RESET.
- START pulse at cycle t:
  - CORE_RST=1 during t+1..t+RST_CYCLES.
  - CEXEC=1 from t+RST_CYCLES+1.
- Exit condition sampled at cycle t: CEXEC=0 at t+1, DONE pulse at t+1, with REASON/RESULT_STAT valid from t+1.
- Timeout: exactly MAXCYC cycles with CEXEC=1; the final CYCLES value equals MAXCYC.
- STEP: exactly one CEXEC=1 cycle, appearing in the cycle after the pulse.

## Configuration
- CORE_SEQ_BREAKPOINT_EN defined:
  - Adds port BKPT_CYCLE (in, 32; 0 = disabled).
  - In RUN, when CYCLES becomes equal to BKPT_CYCLE, go to PAUSE with CEXEC=0 on the next cycle. A resume from PAUSE does not re-trigger at the same value.
  - Priority order: fault > halt > timeout > breakpoint > STOP.
- Undefined: the port is absent and there is no breakpoint logic.

## Test plan
- Reset, then START with ADDR=0x1000, MAXCYC=0, RST_CYCLES=4 -> CORE_RST high 4 cycles, CEXEC high from the 5th cycle after the pulse, CMEM_ADDR=0x1000.
- RUN with CSTAT=0x8000 asserted after 10 exec cycles -> DONE pulse, REASON=1, CYCLES=10, RESULT_STAT=0x8000.
- MAXCYC=25, core never halts -> exactly 25 CEXEC cycles, REASON=2, CYCLES=25.
- STOP at cycle 7, then STEP×3, then START -> PAUSE with CYCLES=7, then 3 single CEXEC pulses (CYCLES=10), then RUN resumes.
- CSTAT=0xC000 and CMD_STOP in the same cycle -> DONE with REASON=3; a second STOP in PAUSE also gives REASON=3. CRST mid-RUN -> IDLE with all outputs at reset values and no DONE pulse.
- (CORE_SEQ_BREAKPOINT_EN) BKPT_CYCLE=12 -> PAUSE with CYCLES=12; START resumes without re-trigger.
